gf_array_feeder: RTL



---
 rtl/gf_array_feeder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gf_array_feeder.sv
// Head-of-chain sequencer: turns one command plus an operand stream into per-cycle chain beats.
// Optional macro FEEDER_DRAIN_EN appends N drain beats that shift results out of the chain.
module gf_array_feeder #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N           = 16,
  parameter int LEN_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_CODE_LEN-1:0] cmd_op,
  input  logic [1:0]             cmd_gauss_op,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [GF_BIT-1:0]      src_data,
  input  logic [GF_BIT-1:0]      src_dataB,
  input  logic [GF_BIT-1:0]      src_dataA,
  output logic                   start_out,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic [GF_BIT-1:0]      data_out,
  output logic [GF_BIT-1:0]      dataB_out,
  output logic [GF_BIT-1:0]      dataA_out,
  output logic                   busy,
  output logic                   done
);

  if (N < 1) begin : g_bad_n
    $error("gf_array_feeder: N must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1
`ifdef FEEDER_DRAIN_EN
    , S_DRAIN = 2'd2
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [OP_CODE_LEN-1:0] op_q, op_d;
  logic [1:0]             gauss_q, gauss_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   first_q, first_d;
  logic                   done_q, done_d;
  logic                   start_q, start_d;
  logic [OP_CODE_LEN-1:0] op_out_q, op_out_d;
  logic [1:0]             gauss_out_q, gauss_out_d;
  logic [GF_BIT-1:0]      data_q, data_d;
  logic [GF_BIT-1:0]      datab_q, datab_d;
  logic [GF_BIT-1:0]      dataa_q, dataa_d;
`ifdef FEEDER_DRAIN_EN
  localparam int DCW = $clog2(N) + 1;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gauss_d     = gauss_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    first_d     = first_q;
    done_d      = 1'b0;
    start_d     = 1'b0;
    op_out_d    = '0;
    gauss_out_d = 2'b00;
    data_d      = '0;
    datab_d     = '0;
    dataa_d     = '0;
`ifdef FEEDER_DRAIN_EN
    drain_cnt_d = drain_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          gauss_d    = cmd_gauss_op;
          len_d      = cmd_len;
          beat_cnt_d = '0;
          first_d    = 1'b1;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A stalled source leaves the all-zero bubble defaults in place.
        if (src_valid) begin
          start_d     = first_q;
          op_out_d    = op_q;
          gauss_out_d = gauss_q;
          data_d      = src_data;
          datab_d     = src_dataB;
          dataa_d     = src_dataA;
          first_d     = 1'b0;
          beat_cnt_d  = beat_cnt_q + LEN_W'(1);
          if (beat_cnt_d == len_q) begin
`ifdef FEEDER_DRAIN_EN
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef FEEDER_DRAIN_EN
      S_DRAIN: begin
        op_out_d    = op_q;
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (drain_cnt_q == DCW'(N - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      gauss_q     <= 2'b00;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      op_out_q    <= '0;
      gauss_out_q <= 2'b00;
      data_q      <= '0;
      datab_q     <= '0;
      dataa_q     <= '0;
`ifdef FEEDER_DRAIN_EN
      drain_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      gauss_q     <= gauss_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      first_q     <= first_d;
      done_q      <= done_d;
      start_q     <= start_d;
      op_out_q    <= op_out_d;
      gauss_out_q <= gauss_out_d;
      data_q      <= data_d;
      datab_q     <= datab_d;
      dataa_q     <= dataa_d;
`ifdef FEEDER_DRAIN_EN
      drain_cnt_q <= drain_cnt_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign src_ready    = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign start_out    = start_q;
  assign op_out       = op_out_q;
  assign gauss_op_out = gauss_out_q;
  assign data_out     = data_q;
  assign dataB_out    = datab_q;
  assign dataA_out    = dataa_q;

endmodule
